// File: rtl/mem_arbiter.sv
// Shares the external memory bus between multi-beat I-cache block refills and
// single-beat data loads/stores; data side has fixed priority, grants only from IDLE.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          ic_req_i,
  input  logic [ADDR_WIDTH-1:0]         ic_addr_i,
  output logic                          ic_rvalid_o,
  output logic [31:0]                   ic_rdata_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] ic_beat_o,
  output logic                          ic_done_o,
  input  logic                          d_req_i,
  input  logic                          d_we_i,
  input  logic [ADDR_WIDTH-1:0]         d_addr_i,
  input  logic [31:0]                   d_wdata_i,
  input  logic [3:0]                    d_be_i,
  output logic [31:0]                   d_rdata_o,
  output logic                          d_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic                          mem_ready_i,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          mem_busy_o
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = BEAT_W + 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_IC_BURST = 2'd1;
  localparam logic [1:0] ST_D_ACCESS = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  logic [1:0]            state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [ADDR_WIDTH-1:0] ic_base_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;

  logic                  beat_done;
  logic                  ic_fire;
  logic                  d_fire;
  logic                  ic_last;
  logic [BEAT_W-1:0]     beat_nxt;

  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] mask;
    mask = {ADDR_WIDTH{1'b1}} << OFF_W;
    return addr & mask;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [BEAT_W-1:0]     beat);
    return base | ADDR_WIDTH'({beat, 2'b00});
  endfunction

  // A beat retires only while the bus is requested; a reset cycle retires nothing.
  assign beat_done = mem_req_q & mem_ready_i & ~reset_i;
  assign ic_fire   = beat_done & (state_q == ST_IC_BURST);
  assign d_fire    = beat_done & (state_q == ST_D_ACCESS);
  assign ic_last   = (beat_q == LAST_BEAT);
  assign beat_nxt  = beat_q + BEAT_W'(1);

  assign ic_rvalid_o = ic_fire;
  assign ic_rdata_o  = ic_fire ? mem_rdata_i : 32'd0;
  assign ic_beat_o   = ic_fire ? beat_q : '0;
  assign ic_done_o   = ic_fire & ic_last;

  assign d_done_o    = d_fire;
  assign d_rdata_o   = (d_fire & ~mem_we_q) ? mem_rdata_i : 32'd0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign mem_busy_o  = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      ic_base_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_req_i) begin
            state_q     <= ST_D_ACCESS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            mem_be_q    <= d_be_i;
          end else if (ic_req_i) begin
            state_q     <= ST_IC_BURST;
            beat_q      <= '0;
            ic_base_q   <= block_base(ic_addr_i);
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= block_base(ic_addr_i);
            mem_wdata_q <= '0;
            mem_be_q    <= 4'hF;
          end
        end
        ST_IC_BURST: begin
          if (mem_ready_i) begin
            // Counter wraps to 0 naturally on the last beat of the block.
            beat_q <= beat_nxt;
            if (ic_last) begin
              state_q     <= ST_IDLE;
              mem_req_q   <= 1'b0;
              mem_addr_q  <= '0;
              mem_be_q    <= '0;
            end else begin
              mem_addr_q  <= beat_addr(ic_base_q, beat_nxt);
            end
          end
        end
        ST_D_ACCESS: begin
          if (mem_ready_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: agents queue expected transactions, a
// transaction-level model in the monitor decides bus ownership and checks every cycle.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } d_txn_t;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          ic_req_i;
  logic [AW-1:0] ic_addr_i;
  logic          ic_rvalid_o;
  logic [31:0]   ic_rdata_o;
  logic [1:0]    ic_beat_o;
  logic          ic_done_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [31:0]   d_wdata_i;
  logic [3:0]    d_be_i;
  logic [31:0]   d_rdata_o;
  logic          d_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_ready_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_busy_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o(ic_rdata_o), .ic_beat_o(ic_beat_o), .ic_done_o(ic_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .mem_busy_o(mem_busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  logic [31:0] ic_q[$];
  d_txn_t      d_q[$];
  int checks = 0;
  int errors = 0;
  int owner  = 0;  // 0 none, 1 refill, 2 data
  int beat_m = 0;
  int ready_mode = 0;
  int wait_n = 0;
  int wcnt = 0;
  bit mon_en = 1'b0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet_completions(input string tag);
    chk({tag, "_ic_rvalid"}, 32'(ic_rvalid_o), 32'd0);
    chk({tag, "_ic_rdata"},  ic_rdata_o,       32'd0);
    chk({tag, "_ic_beat"},   32'(ic_beat_o),   32'd0);
    chk({tag, "_ic_done"},   32'(ic_done_o),   32'd0);
    chk({tag, "_d_done"},    32'(d_done_o),    32'd0);
    chk({tag, "_d_rdata"},   d_rdata_o,        32'd0);
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req_o),   32'd0);
    chk({tag, "_busy"},      32'(mem_busy_o),  32'd0);
    chk({tag, "_mem_we"},    32'(mem_we_o),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr_o,       32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o,      32'd0);
    chk({tag, "_mem_be"},    32'(mem_be_o),    32'd0);
  endtask

  task automatic monitor_cycle();
    logic [31:0] ea;
    d_txn_t t;
    if (reset_i) begin
      chk("rst_ic_done", 32'(ic_done_o), 32'd0);
      chk("rst_ic_rvalid", 32'(ic_rvalid_o), 32'd0);
      chk("rst_d_done", 32'(d_done_o), 32'd0);
      if (owner == 0) chk_bus_idle("rst");
      if (owner == 1) ic_q.delete(0);
      else if (owner == 2) d_q.delete(0);
      owner = 0;
      beat_m = 0;
    end else if (owner == 0) begin
      chk_bus_idle("idle");
      chk_quiet_completions("idle");
      if (d_req_i) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_grant: data request with no queued transaction");
        end else owner = 2;
      end else if (ic_req_i) begin
        if (ic_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ic_grant: refill request with no queued transaction");
        end else begin
          owner = 1;
          beat_m = 0;
        end
      end
    end else if (owner == 1) begin
      ea = ic_q[0] + 32'(4 * beat_m);
      chk("ic_busy", 32'(mem_busy_o), 32'd1);
      chk("ic_mem_req", 32'(mem_req_o), 32'd1);
      chk("ic_mem_addr", mem_addr_o, ea);
      chk("ic_mem_we", 32'(mem_we_o), 32'd0);
      chk("ic_mem_be", 32'(mem_be_o), 32'hF);
      chk("ic_mem_wdata", mem_wdata_o, 32'd0);
      chk("ic_d_done", 32'(d_done_o), 32'd0);
      chk("ic_d_rdata", d_rdata_o, 32'd0);
      if (mem_ready_i) begin
        chk("ic_rvalid", 32'(ic_rvalid_o), 32'd1);
        chk("ic_beat", 32'(ic_beat_o), 32'(beat_m));
        chk("ic_rdata", ic_rdata_o, hash(ea));
        chk("ic_done", 32'(ic_done_o), 32'(beat_m == BW - 1));
        beat_m++;
        if (beat_m == BW) begin
          ic_q.delete(0);
          owner = 0;
          beat_m = 0;
        end
      end else begin
        chk("ic_wait_rvalid", 32'(ic_rvalid_o), 32'd0);
        chk("ic_wait_done", 32'(ic_done_o), 32'd0);
        chk("ic_wait_rdata", ic_rdata_o, 32'd0);
        chk("ic_wait_beat", 32'(ic_beat_o), 32'd0);
      end
    end else begin
      t = d_q[0];
      chk("d_busy", 32'(mem_busy_o), 32'd1);
      chk("d_mem_req", 32'(mem_req_o), 32'd1);
      chk("d_mem_addr", mem_addr_o, t.addr);
      chk("d_mem_we", 32'(mem_we_o), 32'(t.we));
      chk("d_mem_wdata", mem_wdata_o, t.wdata);
      chk("d_mem_be", 32'(mem_be_o), 32'(t.be));
      chk("d_ic_rvalid", 32'(ic_rvalid_o), 32'd0);
      chk("d_ic_done", 32'(ic_done_o), 32'd0);
      if (mem_ready_i) begin
        chk("d_done", 32'(d_done_o), 32'd1);
        chk("d_rdata", d_rdata_o, t.we ? 32'd0 : hash(t.addr));
        d_q.delete(0);
        owner = 0;
      end else begin
        chk("d_wait_done", 32'(d_done_o), 32'd0);
        chk("d_wait_rdata", d_rdata_o, 32'd0);
      end
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    if (mon_en) monitor_cycle();
  end

  // Memory responder: read data is a fixed function of the address; stores see all-ones.
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'd0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: mem_ready_i = 1'b1;
        1: mem_ready_i = ~mem_ready_i;
        2: begin
          if (!mem_req_o) wcnt = 0;
          mem_ready_i = mem_req_o && (wcnt == wait_n);
          if (mem_req_o) wcnt = mem_ready_i ? 0 : wcnt + 1;
        end
        default: mem_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      mem_rdata_i = mem_we_o ? 32'hFFFF_FFFF : hash(mem_addr_o);
    end
  end

  task automatic ic_refill(input logic [31:0] addr, input bit scramble);
    bit done_seen;
    bit aborted;
    bit scrambled;
    @(posedge clk_i);
    #1;
    ic_q.push_back(addr & ~32'(BW * 4 - 1));
    ic_addr_i = addr;
    ic_req_i  = 1'b1;
    done_seen = 1'b0;
    aborted   = 1'b0;
    scrambled = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (reset_i) begin aborted = 1'b1; break; end
      if (ic_done_o) begin done_seen = 1'b1; break; end
      if (scramble && ic_rvalid_o && !scrambled) begin
        scrambled = 1'b1;
        ic_addr_i = $urandom;
        if ($urandom_range(0, 1) == 1) ic_req_i = 1'b0;
      end
    end
    if (!done_seen && !aborted) begin
      checks++; errors++;
      $display("FAIL ic_timeout: refill of %h got no done, required done within 400 cycles", addr);
    end
    @(posedge clk_i);
    #1;
    ic_req_i  = 1'b0;
    ic_addr_i = $urandom;
  endtask

  task automatic d_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be);
    d_txn_t t;
    bit done_seen;
    @(posedge clk_i);
    #1;
    t.we = we; t.addr = addr; t.wdata = wd; t.be = be;
    d_q.push_back(t);
    d_we_i = we; d_addr_i = addr; d_wdata_i = wd; d_be_i = be;
    d_req_i = 1'b1;
    done_seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (d_done_o) begin done_seen = 1'b1; break; end
    end
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL d_timeout: access to %h got no done, required done within 400 cycles", addr);
    end
    @(posedge clk_i);
    #1;
    d_req_i = 1'b0;
    d_we_i = $urandom_range(0, 1) == 1;
    d_addr_i = $urandom;
    d_wdata_i = $urandom;
    d_be_i = 4'($urandom);
  endtask

  task automatic wait_beat(input int b);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (ic_rvalid_o && ic_beat_o == 2'(b)) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL beat_wait: beat %0d never seen, required within 400 cycles", b);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    ic_req_i = 1'b0; ic_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    ready_mode = 0;
    ic_refill(32'h0000_104C, 1'b0);

    ready_mode = 2; wait_n = 2;
    fork
      d_access(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      ic_refill(32'h0000_3008, 1'b0);
    join

    ready_mode = 0;
    fork
      ic_refill(32'h0000_5004, 1'b0);
      begin
        wait_beat(1);
        d_access(1'b1, 32'h0000_6000, 32'h0000_1234, 4'b0011);
      end
    join

    ready_mode = 1;
    ic_refill(32'h0000_7018, 1'b1);

    // Reset lands while the counter is on beat 2.
    ready_mode = 0;
    fork
      ic_refill(32'h0000_8028, 1'b0);
      begin
        wait_beat(1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
      end
    join
    ic_refill(32'h0000_8028, 1'b0);

    d_access(1'b1, 32'h0000_9000, 32'hCAFE_F00D, 4'hF);

    for (int m = 0; m < 3; m++) begin
      ready_mode = (m == 0) ? 3 : m - 1;
      fork
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_i);
          ic_refill($urandom, $urandom_range(0, 1) == 1);
        end
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk_i);
          d_access($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
        end
      join
    end

    repeat (4) @(posedge clk_i);
    #1;
    if (ic_q.size() != 0 || d_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d refills and %0d data accesses left, required 0 and 0",
               ic_q.size(), d_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory bus between the instruction-cache refill port and the data load/store port.
- Sequences multi-beat instruction-cache block refills and single-beat data accesses.
- Reports bus occupancy so the pipeline stall logic can hold the affected stages while an access is in flight.
- Sits between the L1 instruction cache / memory stage and the memory interface.

Parameters:
- ADDR_WIDTH, 32, byte-address width of all address ports.
- BLOCK_WORDS, 4, 32-bit words per instruction-cache block; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- ic_req_i  in  1  instruction-cache refill request; held until ic_done_o
- ic_addr_i  in  ADDR_WIDTH  miss address (any byte within the block)
- ic_rvalid_o  out  1  refill beat valid
- ic_rdata_o  out  32  refill beat data
- ic_beat_o  out  $clog2(BLOCK_WORDS)  word index of the current beat within the block
- ic_done_o  out  1  final beat of refill
- d_req_i  in  1  data access request; held until d_done_o
- d_we_i  in  1  1 = store
- d_addr_i  in  ADDR_WIDTH  word-aligned data address
- d_wdata_i  in  32  store data
- d_be_i  in  4  store byte enables
- d_rdata_o  out  32  load data, valid while d_done_o
- d_done_o  out  1  data access complete
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  ADDR_WIDTH  bus address
- mem_wdata_o  out  32  bus write data
- mem_be_o  out  4  bus byte enables
- mem_ready_i  in  1  beat accepted / completed this cycle
- mem_rdata_i  in  32  bus read data, valid with mem_ready_i
- mem_busy_o  out  1  arbiter not idle

Behaviour:
- FSM states: IDLE, IC_BURST, D_ACCESS. State, latched request fields and beat counter are registered. All bus outputs are driven from registers.
- Reset: state IDLE, beat counter 0, latched fields 0. Every output is 0.
- Reset asserted mid-transaction abandons the transaction. mem_req_o is 0 from the cycle after the reset edge, and no done pulse is issued.
- Arbitration in IDLE:
  - d_req_i has fixed priority: go to D_ACCESS and latch we/addr/wdata/be.
  - Otherwise, if ic_req_i, go to IC_BURST. Latch the block base as ic_addr_i with the low $clog2(BLOCK_WORDS)+2 bits cleared, and clear the beat counter.
  - Arbitration decisions are taken only in IDLE. An active transaction is never preempted.
- Bus outputs:
  - IDLE: mem_req_o=0 and all other mem_* outputs 0.
  - D_ACCESS: mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o come from the latched data request.
  - IC_BURST: mem_req_o=1, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_addr_o = base + 4*beat.
- A beat completes in any cycle with mem_req_o & mem_ready_i. mem_ready_i is ignored in IDLE.
- IC_BURST beat completion:
  - Same cycle (combinational): ic_rvalid_o=1, ic_rdata_o=mem_rdata_i, ic_beat_o=counter.
  - Counter increments at the edge.
  - On the beat with counter==BLOCK_WORDS-1, ic_done_o=1, the counter wraps to 0, and next state is IDLE.
- D_ACCESS completion (same cycle):
  - d_done_o=1; next state IDLE.
  - d_rdata_o=mem_rdata_i for loads, 0 for stores.
- Zero wait states: mem_ready_i may be high on the first cycle of a state. Back-to-back beats proceed one per cycle.
- Wait states: mem_ready_i low holds the state, counter and all bus outputs stable.
- After a completion the FSM always spends at least one cycle in IDLE before the next grant. Requesters drop their request on the edge where done is seen, so no duplicate grant occurs.
- A requester deasserting its request mid-transaction is ignored; the transaction runs to completion.
- Request fields are sampled only at grant. Changes while granted are ignored.
- Outputs are zero outside the defined events: ic_rvalid_o, ic_rdata_o, ic_beat_o, ic_done_o, d_rdata_o and d_done_o are 0 in every cycle without the corresponding completion.
- mem_busy_o = (state != IDLE).

Test Plan:
- ic_req_i=1, ic_addr_i=0x0000_104C, mem_ready_i always 1 -> mem_addr_o 0x1040, 0x1044, 0x1048, 0x104C on 4 consecutive cycles; ic_beat_o 0..3; ic_done_o only on beat 3; mem_busy_o high 4 cycles.
- d_req_i and ic_req_i rise together, load from 0x2000, mem_rdata_i=0xDEADBEEF, 2 wait states -> D_ACCESS first; d_done_o on cycle 3 with d_rdata_o=0xDEADBEEF; one IDLE cycle; then refill starts.
- d_req_i asserted during beat 1 of a refill -> refill completes all 4 beats uninterrupted; data store (d_be_i=4'b0011, d_wdata_i=0x1234) issued after one IDLE cycle with mem_we_o=1, mem_be_o=4'b0011.
- Refill with mem_ready_i toggling 0/1 every cycle -> mem_addr_o and ic_beat_o stable during low cycles; exactly 4 ic_rvalid_o pulses; done after 8 cycles.
- reset_i pulsed during beat 2 of a refill -> next cycle mem_req_o=0, mem_busy_o=0, no ic_done_o; a new ic_req_i restarts at beat 0 of the base address.
- Store with mem_rdata_i=0xFFFFFFFF -> d_done_o=1 with d_rdata_o=0.
